// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the 5-stage MIPS pipeline: datapath widths, the
// primary opcode encodings seen by the back end, and the bubble instruction.
// No ports; imported by wb_decode and wb_regfile.
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int OPCODE_W   = 6;

    // Primary opcodes (instr[31:26])
    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_ADDIU = 6'b001001;
    localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPCODE_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;

    // All-zero word injected by the pipeline as a bubble
    localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000;

    // Extract the primary opcode field from an instruction word
    function automatic logic [OPCODE_W-1:0] get_opcode(input logic [DATA_W-1:0] instr);
        return instr[31:26];
    endfunction

    // True when the instruction word is a pipeline bubble
    function automatic logic is_bubble(input logic [DATA_W-1:0] instr);
        return (instr == NOP_INSTR);
    endfunction

endpackage : mips_pkg

// File: rtl/wb_decode.sv
// -----------------------------------------------------------------------------
// wb_decode
// Purely combinational writeback decode. Determines whether the instruction
// in MEM/WB writes the register file and which source supplies the data.
// Shared with the hazard/forwarding unit so both agree on "who writes".
//
// Ports:
//   instr_i    in  32  instruction word from MEM/WB (0 = bubble)
//   wb_rd_i    in  5   destination register from MEM/WB
//   wb_en_o    out 1   architecturally visible write (never to r0)
//   sel_mem_o  out 1   1: write data comes from memory (load), 0: ALU result
// -----------------------------------------------------------------------------
module wb_decode
    import mips_pkg::*;
(
    input  logic [DATA_W-1:0]     instr_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    output logic                  wb_en_o,
    output logic                  sel_mem_o
);

    logic [OPCODE_W-1:0] opcode_s;
    logic                writes_s;

    assign opcode_s = get_opcode(instr_i);

    // Opcode decode: classify the instruction as writer / non-writer and
    // pick the data source.
    always_comb begin
        writes_s  = 1'b0;
        sel_mem_o = 1'b0;
        case (opcode_s)
            // An all-zero R-type word is a bubble, not sll r0,r0,0 worth writing
            OP_RTYPE: begin
                writes_s  = !is_bubble(instr_i);
                sel_mem_o = 1'b0;
            end
            OP_LW: begin
                writes_s  = 1'b1;
                sel_mem_o = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
                writes_s  = 1'b1;
                sel_mem_o = 1'b0;
            end
            // sw, beq, bne, j and anything unrecognised leave the file alone
            default: begin
                writes_s  = 1'b0;
                sel_mem_o = 1'b0;
            end
        endcase
    end

    // r0 is hard-wired to zero, so a write aimed at it is never visible
    always_comb begin
        if (wb_rd_i != 5'd0) begin
            wb_en_o = writes_s;
        end else begin
            wb_en_o = 1'b0;
        end
    end

endmodule : wb_decode

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
// Writeback stage and architectural 32x32 register file. Consumes the MEM/WB
// registers, selects load data or ALU result, writes the file on the rising
// edge, and serves the two ID-stage read ports with write-first bypass so a
// value being written is visible to readers in the same cycle. Also publishes
// the current writeback for forwarding and counts retired (non-bubble)
// instructions.
//
// Parameters:
//   COUNT_W        width of the retired-instruction counter (wraps, no saturation)
//
// Ports:
//   clk            in  1        clock, rising edge
//   reset          in  1        asynchronous, active-high, clears all state
//   mem_data_i     in  32       load data from MEM/WB
//   alu_result_i   in  32       ALU result / address from MEM/WB
//   wb_rd_i        in  5        destination register from MEM/WB
//   instr_i        in  32       instruction word from MEM/WB (0 = bubble)
//   rs_addr_i      in  5        read port A address
//   rt_addr_i      in  5        read port B address
//   rs_data_o      out 32       read port A data (combinational)
//   rt_data_o      out 32       read port B data (combinational)
//   wb_en_o        out 1        current writeback is architecturally visible
//   wb_rd_o        out 5        destination of the current writeback
//   wb_data_o      out 32       data of the current writeback
//   retired_o      out COUNT_W  number of non-bubble instructions retired
// -----------------------------------------------------------------------------
module wb_regfile
    import mips_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     mem_data_i,
    input  logic [DATA_W-1:0]     alu_result_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic [DATA_W-1:0]     instr_i,
    input  logic [REG_ADDR_W-1:0] rs_addr_i,
    input  logic [REG_ADDR_W-1:0] rt_addr_i,
    output logic [DATA_W-1:0]     rs_data_o,
    output logic [DATA_W-1:0]     rt_data_o,
    output logic                  wb_en_o,
    output logic [REG_ADDR_W-1:0] wb_rd_o,
    output logic [DATA_W-1:0]     wb_data_o,
    output logic [COUNT_W-1:0]    retired_o
);

    localparam int NUM_REGS = 32;

    // Entry 0 exists only to keep indexing simple; it is cleared on reset
    // and can never be written because wb_en_s is low for rd == 0.
    logic [DATA_W-1:0]  regs_r [0:NUM_REGS-1];
    logic [COUNT_W-1:0] retired_r;

    logic               wb_en_s;
    logic               sel_mem_s;
    logic [DATA_W-1:0]  wb_data_s;
    logic [DATA_W-1:0]  rs_data_s;
    logic [DATA_W-1:0]  rt_data_s;

    // Read-port mux: r0 reads zero, a matching in-flight write wins over
    // the stored value (write-first), otherwise the stored value.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [REG_ADDR_W-1:0] addr,
        input logic                  wr_en,
        input logic [REG_ADDR_W-1:0] wr_addr,
        input logic [DATA_W-1:0]     wr_data,
        input logic [DATA_W-1:0]     stored
    );
        logic [DATA_W-1:0] result;
        if (addr == 5'd0) begin
            result = 32'h0000_0000;
        end else if (wr_en && (addr == wr_addr)) begin
            result = wr_data;
        end else begin
            result = stored;
        end
        return result;
    endfunction

    wb_decode u_wb_decode (
        .instr_i   (instr_i),
        .wb_rd_i   (wb_rd_i),
        .wb_en_o   (wb_en_s),
        .sel_mem_o (sel_mem_s)
    );

    // Writeback data select between load data and ALU result
    always_comb begin
        if (sel_mem_s) begin
            wb_data_s = mem_data_i;
        end else begin
            wb_data_s = alu_result_i;
        end
    end

    // Both read ports, each with independent bypass from the writeback
    always_comb begin
        rs_data_s = read_port(rs_addr_i, wb_en_s, wb_rd_i, wb_data_s, regs_r[rs_addr_i]);
        rt_data_s = read_port(rt_addr_i, wb_en_s, wb_rd_i, wb_data_s, regs_r[rt_addr_i]);
    end

    // Register file storage: cleared by reset, one write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= 32'h0000_0000;
            end
        end else if (wb_en_s) begin
            regs_r[wb_rd_i] <= wb_data_s;
        end
    end

    // Retired-instruction counter; counts every non-bubble, wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_r <= '0;
        end else if (!is_bubble(instr_i)) begin
            retired_r <= retired_r + COUNT_W'(1);
        end
    end

    assign rs_data_o = rs_data_s;
    assign rt_data_o = rt_data_s;
    assign wb_en_o   = wb_en_s;
    assign wb_rd_o   = wb_rd_i;
    assign wb_data_o = wb_data_s;
    assign retired_o = retired_r;

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile
// Directed self-checking bench for wb_regfile (COUNT_W = 4 so counter wrap
// is reachable in a few cycles).
// -----------------------------------------------------------------------------
module tb_wb_regfile;

    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic [31:0]   mem_data_i;
    logic [31:0]   alu_result_i;
    logic [4:0]    wb_rd_i;
    logic [31:0]   instr_i;
    logic [4:0]    rs_addr_i;
    logic [4:0]    rt_addr_i;
    logic [31:0]   rs_data_o;
    logic [31:0]   rt_data_o;
    logic          wb_en_o;
    logic [4:0]    wb_rd_o;
    logic [31:0]   wb_data_o;
    logic [CW-1:0] retired_o;

    int            errors;
    int            checks;
    logic [CW-1:0] exp_cnt;

    wb_regfile #(.COUNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_data_i   (mem_data_i),
        .alu_result_i (alu_result_i),
        .wb_rd_i      (wb_rd_i),
        .instr_i      (instr_i),
        .rs_addr_i    (rs_addr_i),
        .rt_addr_i    (rt_addr_i),
        .rs_data_o    (rs_data_o),
        .rt_data_o    (rt_data_o),
        .wb_en_o      (wb_en_o),
        .wb_rd_o      (wb_rd_o),
        .wb_data_o    (wb_data_o),
        .retired_o    (retired_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, update the expected retire count, settle
    task automatic tick();
        @(posedge clk);
        if (!reset && instr_i != 32'h0) exp_cnt = exp_cnt + 4'd1;
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] mem);
        instr_i      = instr;
        wb_rd_i      = rd;
        alu_result_i = alu;
        mem_data_i   = mem;
        #1;
    endtask

    task automatic bubble();
        drive(32'h0, 5'd0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bubble();
        rs_addr_i = 5'd5;
        rt_addr_i = 5'd5;
        #2;
        checks++;
        if (retired_o !== 4'd0) begin
            errors++; $display("FAIL reset_cnt got=%0d exp=0", retired_o);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        exp_cnt = 4'd0;
        // write r5 = DEADBEEF with addi
        drive(32'h2005_BEEF, 5'd5, 32'hDEAD_BEEF, 32'h0);
        tick();
        bubble();
        checks++;
        if (rs_data_o !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL pre_reset_r5 got=%h exp=deadbeef", rs_data_o);
        end
        checks++;
        if (retired_o !== exp_cnt) begin
            errors++; $display("FAIL pre_reset_cnt got=%0d exp=%0d", retired_o, exp_cnt);
        end
        // mid-cycle asynchronous reset, with a writer presented meanwhile
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (rs_data_o !== 32'h0) begin
            errors++; $display("FAIL reset_r5 got=%h exp=0", rs_data_o);
        end
        checks++;
        if (retired_o !== 4'd0) begin
            errors++; $display("FAIL reset_cnt_mid got=%0d exp=0", retired_o);
        end
        drive(32'h2006_0011, 5'd6, 32'h0000_0011, 32'h0);
        @(posedge clk); #1;
        bubble();
        reset = 1'b0;
        exp_cnt = 4'd0;
        rs_addr_i = 5'd6;
        #1;
        checks++;
        if (rs_data_o !== 32'h0) begin
            errors++; $display("FAIL reset_no_write got=%h exp=0", rs_data_o);
        end
        checks++;
        if (retired_o !== 4'd0) begin
            errors++; $display("FAIL reset_no_count got=%0d exp=0", retired_o);
        end
    endtask

    task automatic test_rtype();
        rs_addr_i = 5'd3;
        rt_addr_i = 5'd3;
        drive(32'h0022_1820, 5'd3, 32'h1234_5678, 32'h0BAD_0BAD);
        checks++;
        if (wb_en_o !== 1'b1) begin
            errors++; $display("FAIL rtype_en got=%b exp=1", wb_en_o);
        end
        checks++;
        if (wb_rd_o !== 5'd3 || wb_data_o !== 32'h1234_5678) begin
            errors++; $display("FAIL rtype_wb got=%0d/%h exp=3/12345678", wb_rd_o, wb_data_o);
        end
        checks++;
        if (rs_data_o !== 32'h1234_5678 || rt_data_o !== 32'h1234_5678) begin
            errors++; $display("FAIL rtype_bypass got=%h/%h exp=12345678", rs_data_o, rt_data_o);
        end
        tick();
        bubble();
        checks++;
        if (rs_data_o !== 32'h1234_5678) begin
            errors++; $display("FAIL rtype_stored got=%h exp=12345678", rs_data_o);
        end
        checks++;
        if (retired_o !== 4'd1) begin
            errors++; $display("FAIL rtype_cnt got=%0d exp=1", retired_o);
        end
    endtask

    task automatic test_load();
        rt_addr_i = 5'd7;
        drive(32'h8C07_1000, 5'd7, 32'h0000_1000, 32'hCAFE_F00D);
        checks++;
        if (wb_en_o !== 1'b1 || wb_data_o !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL load_sel got=%b/%h exp=1/cafef00d", wb_en_o, wb_data_o);
        end
        tick();
        bubble();
        checks++;
        if (rt_data_o !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL load_stored got=%h exp=cafef00d", rt_data_o);
        end
    endtask

    task automatic test_nonwriters();
        rs_addr_i = 5'd9;
        drive(32'hAC09_0000, 5'd9, 32'hFFFF_FFFF, 32'h0);
        checks++;
        if (wb_en_o !== 1'b0) begin
            errors++; $display("FAIL sw_en got=%b exp=0", wb_en_o);
        end
        checks++;
        if (rs_data_o !== 32'h0) begin
            errors++; $display("FAIL sw_no_bypass got=%h exp=0", rs_data_o);
        end
        tick();
        drive(32'h1000_0004, 5'd9, 32'hFFFF_FFFF, 32'h0);  // beq
        checks++;
        if (wb_en_o !== 1'b0) begin
            errors++; $display("FAIL beq_en got=%b exp=0", wb_en_o);
        end
        tick();
        drive(32'h0800_0010, 5'd9, 32'hFFFF_FFFF, 32'h0);  // j
        checks++;
        if (wb_en_o !== 1'b0) begin
            errors++; $display("FAIL j_en got=%b exp=0", wb_en_o);
        end
        tick();
        bubble();
        checks++;
        if (rs_data_o !== 32'h0) begin
            errors++; $display("FAIL sw_unchanged got=%h exp=0", rs_data_o);
        end
        checks++;
        if (retired_o !== exp_cnt) begin
            errors++; $display("FAIL nonwriter_cnt got=%0d exp=%0d", retired_o, exp_cnt);
        end
        tick();
        checks++;
        if (retired_o !== exp_cnt) begin
            errors++; $display("FAIL bubble_cnt got=%0d exp=%0d", retired_o, exp_cnt);
        end
    endtask

    task automatic test_r0();
        rs_addr_i = 5'd0;
        rt_addr_i = 5'd0;
        drive(32'h2000_0055, 5'd0, 32'h0000_0055, 32'h0);
        checks++;
        if (wb_en_o !== 1'b0) begin
            errors++; $display("FAIL r0_en got=%b exp=0", wb_en_o);
        end
        checks++;
        if (rs_data_o !== 32'h0 || rt_data_o !== 32'h0) begin
            errors++; $display("FAIL r0_same got=%h/%h exp=0", rs_data_o, rt_data_o);
        end
        tick();
        bubble();
        checks++;
        if (rs_data_o !== 32'h0) begin
            errors++; $display("FAIL r0_next got=%h exp=0", rs_data_o);
        end
    endtask

    task automatic test_itypes();
        logic [5:0]  ops [5];
        logic [31:0] instr;
        ops[0] = 6'b001001; ops[1] = 6'b001010; ops[2] = 6'b001100;
        ops[3] = 6'b001101; ops[4] = 6'b001111;
        for (int i = 0; i < 5; i++) begin
            instr = {ops[i], 26'h0};
            rs_addr_i = 5'd10 + 5'(i);
            rt_addr_i = 5'd3;
            drive(instr, 5'd10 + 5'(i), 32'hA000_0000 + 32'(i), 32'h5555_5555);
            checks++;
            if (wb_en_o !== 1'b1 || rs_data_o !== 32'hA000_0000 + 32'(i)) begin
                errors++; $display("FAIL itype_%0d got=%b/%h exp=1/%h", i, wb_en_o, rs_data_o, 32'hA000_0000 + 32'(i));
            end
            checks++;
            if (rt_data_o !== 32'h1234_5678) begin
                errors++; $display("FAIL itype_rt_%0d got=%h exp=12345678", i, rt_data_o);
            end
            tick();
        end
        bubble();
        rs_addr_i = 5'd14;
        rt_addr_i = 5'd7;
        #1;
        checks++;
        if (rs_data_o !== 32'hA000_0004 || rt_data_o !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL itype_stored got=%h/%h exp=a0000004/cafef00d", rs_data_o, rt_data_o);
        end
    endtask

    task automatic test_back_to_back();
        drive(32'h3404_0001, 5'd4, 32'h0000_0001, 32'h0);
        tick();
        rs_addr_i = 5'd4;
        rt_addr_i = 5'd4;
        drive(32'h3404_0002, 5'd4, 32'h0000_0002, 32'h0);
        checks++;
        if (rs_data_o !== 32'h2 || rt_data_o !== 32'h2) begin
            errors++; $display("FAIL b2b_bypass got=%h/%h exp=2", rs_data_o, rt_data_o);
        end
        tick();
        bubble();
        checks++;
        if (rs_data_o !== 32'h2) begin
            errors++; $display("FAIL b2b_stored got=%h exp=2", rs_data_o);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        reset = 1'b1;
        bubble();
        @(posedge clk); #1;
        reset = 1'b0;
        exp_cnt = 4'd0;
        drive(32'hAC01_0000, 5'd1, 32'h0, 32'h0);
        for (int i = 0; i < 17; i++) tick();
        bubble();
        checks++;
        if (retired_o !== 4'd1) begin
            errors++; $display("FAIL wrap_cnt got=%0d exp=1", retired_o);
        end
        checks++;
        if (retired_o !== exp_cnt) begin
            errors++; $display("FAIL wrap_model got=%0d exp=%0d", retired_o, exp_cnt);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        exp_cnt = 4'd0;
        reset = 1'b1;
        instr_i = 32'h0; wb_rd_i = 5'd0; alu_result_i = 32'h0; mem_data_i = 32'h0;
        rs_addr_i = 5'd0; rt_addr_i = 5'd0;
        test_reset();
        test_rtype();
        test_load();
        test_nonwriters();
        test_r0();
        test_itypes();
        test_back_to_back();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_wb_regfile
